uart_cmd_assembler: RTL and testbench
=====================================

UART_CMD_ASSEMBLER -- requirements
Module: uart_cmd_assembler

Interface
REQ-001 Parameter TIMEOUT, default 100000; maximum idle clocks allowed between bytes of one frame.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rx_rdy  input  1  byte-ready flag from the UART receiver; level, held until cleared.
REQ-005 rx_data  input  8  received byte; valid while rx_rdy is high.
REQ-006 clr_rx_rdy  output  1  clears the receiver ready flag; combinational.
REQ-007 clr_cmd_rdy  input  1  consumer acknowledge of cmd; single-cycle pulse.
REQ-008 cmd  output  24  assembled command {opcode, data_hi, data_lo}.
REQ-009 cmd_rdy  output  1  cmd holds a complete frame; level.
REQ-010 frame_err  output  1  one-cycle pulse when a partial frame is discarded on timeout.
REQ-011 overrun  output  1  sticky flag: a frame completed while cmd_rdy was already high.

Function
REQ-012 The frame is 3 bytes in order: opcode, data_hi, data_lo; there is no framing byte and no checksum.
REQ-013 The FSM has states IDLE (0 bytes held), GOT1 (opcode held), and GOT2 (opcode and data_hi held).
REQ-014 A byte is accepted in any state in a cycle where rx_rdy=1; clr_rx_rdy=1 in exactly those cycles, otherwise 0.
REQ-015 Each byte is accepted exactly once, because the receiver drops rdy on the edge after clr_rx_rdy.
REQ-016 An accepted byte in IDLE loads opcode into cmd staging bits [23:16], then IDLE->GOT1.
REQ-017 An accepted byte in GOT1 loads staging bits [15:8], then GOT1->GOT2.
REQ-018 An accepted byte in GOT2 loads bits [7:0] and copies the full 24-bit staging word to cmd on the same edge, then GOT2->IDLE.
REQ-019 cmd_rdy goes high on the edge after the third byte is accepted; this is 1-cycle latency from the rx_rdy sample.
REQ-020 cmd is stable whenever cmd_rdy=1, except when it is overwritten by a new frame completion (REQ-023).
REQ-021 cmd_rdy clears on the edge after clr_cmd_rdy=1.
REQ-022 If frame completion and clr_cmd_rdy occur in the same cycle, the set wins and cmd_rdy stays 1.
REQ-023 If a frame completes while cmd_rdy=1 and there is no same-cycle clr_cmd_rdy, the new frame overwrites cmd, cmd_rdy stays 1, and overrun sets to 1.
REQ-024 overrun clears only on reset.
REQ-025 The timeout counter is wide enough to hold TIMEOUT, and is cleared on every accepted byte and while in IDLE.
REQ-026 The timeout counter increments by 1 per clock in GOT1 and GOT2 while no byte is accepted.
REQ-027 When the counter reaches TIMEOUT-1 with no byte accepted that cycle: the next state is IDLE, the counter clears, and frame_err pulses high for exactly the following cycle.
REQ-028 On timeout, staging data is discarded and cmd and cmd_rdy are unchanged.
REQ-029 If a byte arrives in the same cycle the timeout would fire, the byte wins: normal transition, no frame_err.
REQ-030 The timeout never fires in IDLE, so an arbitrarily long gap before an opcode is legal.
REQ-031 clr_cmd_rdy while cmd_rdy=0 has no effect.
REQ-032 Staging contents are don't-care in IDLE and are never visible on cmd until a frame completes.

Reset
REQ-033 On rst_n low: state=IDLE, counter=0, cmd=24'h000000, cmd_rdy=0, frame_err=0, overrun=0.
REQ-034 clr_rx_rdy=0 whenever rst_n is low, regardless of rx_rdy.
REQ-035 Reset asserted mid-frame discards the partial frame; after release, the next accepted byte is treated as an opcode.
REQ-036 Reset never asserts frame_err.

Verification (bench uses TIMEOUT=50)
REQ-037 Bytes 0x12, 0x34, 0x56 each held on rx_rdy until cleared, gaps of 10 clk -> clr_rx_rdy pulses exactly 3 times, cmd=24'h123456, cmd_rdy rises 1 clk after the third accept, frame_err=0.
REQ-038 Bytes 0xAA then 0xBB, then a 60-clk gap, then 0x01, 0x02, 0x03 -> frame_err pulses once, 50 clk after the 0xBB accept; final cmd=24'h010203; 0xAA and 0xBB never appear on cmd.
REQ-039 Frame 0x111111 left unacknowledged, then frame 0x222222 -> cmd=24'h222222, cmd_rdy=1, overrun=1; overrun persists after clr_cmd_rdy.
REQ-040 clr_cmd_rdy in the same cycle as third-byte acceptance -> cmd_rdy remains 1 and cmd holds the new frame.
REQ-041 Byte presented in the GOT2 cycle where the counter is at 49 -> frame completes, no frame_err.
REQ-042 rst_n pulsed low after 2 bytes, then 3 bytes 0x0A, 0x0B, 0x0C -> all outputs at reset values during reset, then cmd=24'h0A0B0C.

Source files
------------

// File: rtl/uart_cmd_assembler.sv
// Assembles three UART bytes (opcode, data_hi, data_lo) into one 24-bit command.
// A partial frame is abandoned if the gap between bytes reaches TIMEOUT clocks.
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | no bytes of a frame held
// GOT1  | opcode held in staging
// GOT2  | opcode and data_hi held in staging
module uart_cmd_assembler #(
   parameter int TIMEOUT = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_rdy,
   input  logic [7:0]  rx_data,
   output logic        clr_rx_rdy,
   input  logic        clr_cmd_rdy,
   output logic [23:0] cmd,
   output logic        cmd_rdy,
   output logic        frame_err,
   output logic        overrun
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GOT1 = 2'd1,
      GOT2 = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   stage_q, stage_d;    // {opcode, data_hi} awaiting data_lo
   logic [23:0]   cmd_q, cmd_d;
   logic          cmd_rdy_q, cmd_rdy_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;
   logic          accept;

   // A byte is taken whenever the receiver flags one; gated so reset never clears the receiver.
   assign accept     = rx_rdy & rst_n;
   assign clr_rx_rdy = accept;

   assign cmd       = cmd_q;
   assign cmd_rdy   = cmd_rdy_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

   // State, timer, staging and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         stage_q     <= '0;
         cmd_q       <= '0;
         cmd_rdy_q   <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stage_q     <= stage_d;
         cmd_q       <= cmd_d;
         cmd_rdy_q   <= cmd_rdy_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   // Next-state: byte acceptance, frame completion, and inter-byte timeout.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stage_d     = stage_q;
      cmd_d       = cmd_q;
      cmd_rdy_d   = cmd_rdy_q & ~clr_cmd_rdy;
      frame_err_d = 1'b0;
      overrun_d   = overrun_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) begin
               stage_d[15:8] = rx_data;
               state_d       = GOT1;
            end
         end
         GOT1: begin
            if (accept) begin
               cnt_d        = '0;
               stage_d[7:0] = rx_data;
               state_d      = GOT2;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d       = '0;
               frame_err_d = 1'b1;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GOT2: begin
            if (accept) begin
               cnt_d     = '0;
               cmd_d     = {stage_q, rx_data};
               // Completion beats a same-cycle acknowledge; an unacknowledged frame is lost.
               cmd_rdy_d = 1'b1;
               overrun_d = overrun_q | (cmd_rdy_q & ~clr_cmd_rdy);
               state_d   = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d       = '0;
               frame_err_d = 1'b1;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench for uart_cmd_assembler with a frame-level reference model.
module tb_uart_cmd_assembler;

   localparam int TIMEOUT = 50;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_rdy = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        clr_cmd_rdy = 1'b0;
   logic        clr_rx_rdy;
   logic [23:0] cmd;
   logic        cmd_rdy;
   logic        frame_err;
   logic        overrun;

   int total = 0;
   int bad   = 0;

   uart_cmd_assembler #(.TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_rdy      (rx_rdy),
      .rx_data     (rx_data),
      .clr_rx_rdy  (clr_rx_rdy),
      .clr_cmd_rdy (clr_cmd_rdy),
      .cmd         (cmd),
      .cmd_rdy     (cmd_rdy),
      .frame_err   (frame_err),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1);
   end

   // Edge-indexed observation of accepts and frame_err pulses.
   int cyc = 0;
   int clr_cnt = 0;
   int ferr_cnt = 0;
   int accept_edge = -1;
   int ferr_edge = -1;
   bit watch_stale = 0;
   bit saw_stale = 0;

   always @(posedge clk) begin
      cyc++;
      if (clr_rx_rdy) begin
         clr_cnt++;
         accept_edge = cyc;
      end
      if (frame_err) begin
         ferr_cnt++;
         ferr_edge = cyc - 1;
      end
      if (watch_stale && (cmd[23:16] == 8'hAA || cmd[15:8] == 8'hBB)) saw_stale = 1;
   end

   // Reference model: bytes collect in a list; three make a frame; a partial
   // frame is dropped after TIMEOUT idle clocks since its last byte.
   logic [7:0]  pend[$];
   int          idle_cnt = 0;
   logic [23:0] exp_cmd = 24'h0;
   bit          exp_rdy = 0;
   bit          exp_ovr = 0;
   bit          exp_ferr = 0;
   int          exp_ferr_total = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend.delete();
         idle_cnt = 0;
         exp_cmd  = 24'h0;
         exp_rdy  = 0;
         exp_ovr  = 0;
         exp_ferr = 0;
      end else begin
         exp_ferr = 0;
         if (rx_rdy) begin
            pend.push_back(rx_data);
            idle_cnt = 0;
            if (pend.size() == 3) begin
               if (exp_rdy && !clr_cmd_rdy) exp_ovr = 1;
               exp_cmd = {pend[0], pend[1], pend[2]};
               exp_rdy = 1;
               pend.delete();
            end else if (clr_cmd_rdy) begin
               exp_rdy = 0;
            end
         end else begin
            if (clr_cmd_rdy) exp_rdy = 0;
            if (pend.size() > 0) begin
               idle_cnt++;
               if (idle_cnt == TIMEOUT) begin
                  pend.delete();
                  idle_cnt = 0;
                  exp_ferr = 1;
                  exp_ferr_total++;
               end
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit with_clr = 0);
      @(negedge clk);
      rx_data = b;
      rx_rdy = 1'b1;
      clr_cmd_rdy = with_clr;
      @(posedge clk);
      #1;
      rx_rdy = 1'b0;
      clr_cmd_rdy = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr_cmd_rdy = 1'b1;
      @(posedge clk);
      #1;
      clr_cmd_rdy = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rx_rdy = 1'b1;
      rx_data = 8'h5A;
      repeat (3) @(negedge clk);
      total++; if (cmd !== 24'h0) begin bad++; $display("FAIL reset_cmd got=%h want=%h", cmd, 24'h0); end
      total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL reset_cmd_rdy got=%b want=0", cmd_rdy); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
      total++; if (clr_rx_rdy !== 1'b0) begin bad++; $display("FAIL reset_clr_rx_rdy got=%b want=0", clr_rx_rdy); end
      rx_rdy = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_basic();
      int c0, f0;
      c0 = clr_cnt;
      f0 = ferr_cnt;
      send_byte(8'h12);
      idle(10);
      send_byte(8'h34);
      idle(10);
      total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL basic_rdy_early got=%b want=0", cmd_rdy); end
      send_byte(8'h56);
      total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL basic_rdy_latency got=%b want=1", cmd_rdy); end
      total++; if (cmd !== 24'h123456) begin bad++; $display("FAIL basic_cmd got=%h want=%h", cmd, 24'h123456); end
      idle(2);
      total++; if (clr_cnt - c0 !== 3) begin bad++; $display("FAIL basic_clr_pulses got=%0d want=3", clr_cnt - c0); end
      total++; if (ferr_cnt !== f0) begin bad++; $display("FAIL basic_no_ferr got=%0d want=%0d", ferr_cnt, f0); end
      pulse_clr();
      total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL basic_ack got=%b want=0", cmd_rdy); end
      total++; if (cmd !== 24'h123456) begin bad++; $display("FAIL basic_cmd_hold got=%h want=%h", cmd, 24'h123456); end
   endtask

   task automatic test_timeout();
      int f0, ab;
      f0 = ferr_cnt;
      watch_stale = 1;
      saw_stale = 0;
      send_byte(8'hAA);
      idle(5);
      send_byte(8'hBB);
      ab = accept_edge;
      idle(60);
      total++; if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL timeout_pulses got=%0d want=1", ferr_cnt - f0); end
      total++; if (ferr_edge - ab !== TIMEOUT) begin bad++; $display("FAIL timeout_delay got=%0d want=%0d", ferr_edge - ab, TIMEOUT); end
      total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL timeout_rdy got=%b want=0", cmd_rdy); end
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      idle(1);
      total++; if (cmd !== 24'h010203) begin bad++; $display("FAIL timeout_cmd got=%h want=%h", cmd, 24'h010203); end
      total++; if (saw_stale !== 1'b0) begin bad++; $display("FAIL timeout_stale got=%b want=0", saw_stale); end
      total++; if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL timeout_extra got=%0d want=1", ferr_cnt - f0); end
      watch_stale = 0;
      pulse_clr();
   endtask

   task automatic test_same_cycle_clr();
      send_byte(8'hA1);
      send_byte(8'hA2);
      send_byte(8'hA3);
      total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL samecyc_first got=%b want=1", cmd_rdy); end
      send_byte(8'h44);
      send_byte(8'h55);
      send_byte(8'h66, 1'b1);
      total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL samecyc_rdy got=%b want=1", cmd_rdy); end
      total++; if (cmd !== 24'h445566) begin bad++; $display("FAIL samecyc_cmd got=%h want=%h", cmd, 24'h445566); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL samecyc_overrun got=%b want=0", overrun); end
      pulse_clr();
   endtask

   task automatic test_timeout_boundary();
      int f0, e;
      f0 = ferr_cnt;
      send_byte(8'h77);
      send_byte(8'h88);
      e = accept_edge;
      idle(TIMEOUT - 1);
      send_byte(8'h99);
      total++; if (accept_edge - e !== TIMEOUT) begin bad++; $display("FAIL boundary_edge got=%0d want=%0d", accept_edge - e, TIMEOUT); end
      total++; if (cmd !== 24'h778899) begin bad++; $display("FAIL boundary_cmd got=%h want=%h", cmd, 24'h778899); end
      idle(3);
      total++; if (ferr_cnt !== f0) begin bad++; $display("FAIL boundary_ferr got=%0d want=%0d", ferr_cnt, f0); end
      pulse_clr();
   endtask

   task automatic test_overrun();
      repeat (3) send_byte(8'h11);
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_early got=%b want=0", overrun); end
      repeat (3) send_byte(8'h22);
      total++; if (cmd !== 24'h222222) begin bad++; $display("FAIL overrun_cmd got=%h want=%h", cmd, 24'h222222); end
      total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL overrun_rdy got=%b want=1", cmd_rdy); end
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b want=1", overrun); end
      pulse_clr();
      idle(2);
      total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL overrun_ack got=%b want=0", cmd_rdy); end
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%b want=1", overrun); end
   endtask

   task automatic test_reset_midframe();
      int f0;
      send_byte(8'hE1);
      send_byte(8'hE2);
      @(negedge clk);
      f0 = ferr_cnt;
      rst_n = 1'b0;
      rx_data = 8'hE3;
      rx_rdy = 1'b1;
      #1;
      total++; if (clr_rx_rdy !== 1'b0) begin bad++; $display("FAIL rstmid_clr_rx got=%b want=0", clr_rx_rdy); end
      total++; if (cmd !== 24'h0) begin bad++; $display("FAIL rstmid_cmd got=%h want=%h", cmd, 24'h0); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rstmid_overrun got=%b want=0", overrun); end
      total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL rstmid_rdy got=%b want=0", cmd_rdy); end
      @(negedge clk);
      rx_rdy = 1'b0;
      rst_n = 1'b1;
      send_byte(8'h0A);
      send_byte(8'h0B);
      send_byte(8'h0C);
      total++; if (cmd !== 24'h0A0B0C) begin bad++; $display("FAIL rstmid_cmd_after got=%h want=%h", cmd, 24'h0A0B0C); end
      total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL rstmid_rdy_after got=%b want=1", cmd_rdy); end
      idle(TIMEOUT + 5);
      total++; if (ferr_cnt !== f0) begin bad++; $display("FAIL rstmid_ferr got=%0d want=%0d", ferr_cnt, f0); end
      pulse_clr();
   endtask

   task automatic test_random();
      int r, g;
      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         if (r < 7) send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0));
         else if (r < 9) pulse_clr();
         g = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT + 2, TIMEOUT + 15) : $urandom_range(0, 12);
         for (int k = 0; k < g; k++) begin
            @(negedge clk);
            total++; if (frame_err !== exp_ferr) begin bad++; $display("FAIL rand_frame_err step=%0d got=%b want=%b", i, frame_err, exp_ferr); end
         end
         #1;
         total++; if (cmd !== exp_cmd) begin bad++; $display("FAIL rand_cmd step=%0d got=%h want=%h", i, cmd, exp_cmd); end
         total++; if (cmd_rdy !== exp_rdy) begin bad++; $display("FAIL rand_rdy step=%0d got=%b want=%b", i, cmd_rdy, exp_rdy); end
         total++; if (overrun !== exp_ovr) begin bad++; $display("FAIL rand_overrun step=%0d got=%b want=%b", i, overrun, exp_ovr); end
      end
      idle(TIMEOUT + 5);
      total++; if (ferr_cnt !== exp_ferr_total) begin bad++; $display("FAIL rand_ferr_total got=%0d want=%0d", ferr_cnt, exp_ferr_total); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_timeout();
      test_same_cycle_clr();
      test_timeout_boundary();
      test_overrun();
      test_reset_midframe();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
